// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Segment codes use bit i = segment i, 1 = lit (same table as the BCD decode stage).
package digit_scan_pkg;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_ZERO = 8'b0011_1111;

  // Index n holds the pattern for decimal digit n.
  localparam logic [9:0][7:0] SEG_CODES = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
    8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexes one segment bus across four digits with blanking gaps and a frame strobe.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (D0 is always shown).
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int DWELL_CYC = 3000,
  parameter int BLANK_CYC = 16
) (
  input  logic       TIMER,
  input  logic       BUTTON_N,
  input  logic       EN,
  input  logic [7:0] D0,
  input  logic [7:0] D1,
  input  logic [7:0] D2,
  input  logic [7:0] D3,
  output logic [7:0] SEG,
  output logic [3:0] AN,
  output logic       FRAME
);

  localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [1:0]       LAST_IDX   = 2'(NUM_DIGITS - 1);

  if (DWELL_CYC < 2) begin : g_bad_dwell
    $error("digit_scan_ctrl: DWELL_CYC must be >= 2");
  end
  if (BLANK_CYC < 1) begin : g_bad_blank
    $error("digit_scan_ctrl: BLANK_CYC must be >= 1");
  end

  scan_state_t state, state_n;
  logic [1:0]  idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic        running;
  logic        capture;
  logic [NUM_DIGITS-1:0][7:0] snap, snap_n;
  logic [NUM_DIGITS-1:0]      suppress;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_n;

  // A fresh snapshot is taken on the first enabled cycle and whenever digit 3 hands back to digit 0.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    capture = 1'b0;
    if (!EN) begin
      state_n = BLANK;
      idx_n   = 2'd0;
      cnt_n   = '0;
    end else begin
      capture = !running;
      unique case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = DRIVE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (cnt == DWELL_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = idx + 2'd1;
            if (idx == LAST_IDX) capture = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = BLANK;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign snap_n = capture ? {D3, D2, D1, D0} : snap;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is dark only if it shows zero and every more significant digit is dark too.
  always_comb begin
    suppress    = '0;
    suppress[3] = (snap_n[3] == SEG_ZERO);
    suppress[2] = suppress[3] && (snap_n[2] == SEG_ZERO);
    suppress[1] = suppress[2] && (snap_n[1] == SEG_ZERO);
  end
`else
  assign suppress = '0;
`endif

  // Outputs are decoded from the next state so the registered pins line up with the FSM state.
  always_comb begin
    seg_n   = '0;
    an_n    = '0;
    frame_n = 1'b0;
    if (state_n == DRIVE) begin
      frame_n = (idx_n == LAST_IDX) && (cnt_n == DWELL_LAST);
      if (!suppress[idx_n]) begin
        an_n  = 4'b0001 << idx_n;
        seg_n = snap_n[idx_n];
      end
    end
  end

  always_ff @(posedge TIMER or negedge BUTTON_N) begin
    if (!BUTTON_N) begin
      state   <= BLANK;
      idx     <= 2'd0;
      cnt     <= '0;
      running <= 1'b0;
      snap    <= '0;
      SEG     <= '0;
      AN      <= '0;
      FRAME   <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      running <= EN;
      snap    <= snap_n;
      SEG     <= seg_n;
      AN      <= an_n;
      FRAME   <= frame_n;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl (DWELL_CYC=4, BLANK_CYC=2).
// Expected per-cycle bus values are queued from the digit patterns and popped every cycle.
module tb_digit_scan_ctrl;
  import digit_scan_pkg::*;

  localparam int DWELL_LEN = 4;
  localparam int BLANK_LEN = 2;
  localparam int FRAME_LEN = 4 * (DWELL_LEN + BLANK_LEN);
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic       timer = 1'b0;
  logic       button_n;
  logic       en;
  logic [7:0] d0, d1, d2, d3;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame;

  digit_scan_ctrl #(.DWELL_CYC(DWELL_LEN), .BLANK_CYC(BLANK_LEN)) dut (
    .TIMER(timer), .BUTTON_N(button_n), .EN(en),
    .D0(d0), .D1(d1), .D2(d2), .D3(d3),
    .SEG(seg), .AN(an), .FRAME(frame)
  );

  always #5 timer = ~timer;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame;
  } obs_t;

  typedef struct {
    logic [3:0][7:0] d;
    logic [3:0]      lz_mask;
  } vec_t;

  obs_t exp_q[$];
  vec_t vecs[6];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [3:0][7:0] mk(input logic [7:0] a0, a1, a2, a3);
    mk = {a3, a2, a1, a0};
  endfunction

  task automatic push_idle(input int n);
    obs_t o;
    o = '0;
    for (int i = 0; i < n; i++) exp_q.push_back(o);
  endtask

  // One frame: each digit gets BLANK_LEN dark cycles then DWELL_LEN lit cycles.
  task automatic push_frame(input logic [3:0][7:0] d, input logic [3:0] lit);
    obs_t o;
    for (int k = 0; k < 4; k++) begin
      push_idle(BLANK_LEN);
      for (int j = 0; j < DWELL_LEN; j++) begin
        o.an    = lit[k] ? (4'b0001 << k) : 4'b0000;
        o.seg   = lit[k] ? d[k] : 8'h00;
        o.frame = (k == 3) && (j == DWELL_LEN - 1);
        exp_q.push_back(o);
      end
    end
  endtask

  task automatic apply_stimulus(input logic [3:0][7:0] d);
    d0 = d[0]; d1 = d[1]; d2 = d[2]; d3 = d[3];
  endtask

  task automatic check_output(input string tag);
    obs_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: no expectation queued, got an=%b seg=%h frame=%b", tag, an, seg, frame);
      return;
    end
    e = exp_q.pop_front();
    if ({an, seg, frame} !== e) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got an=%b seg=%h frame=%b, expected an=%b seg=%h frame=%b",
               tag, $time, an, seg, frame, e.an, e.seg, e.frame);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge timer);
    #1;
    check_output(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic stop_scan();
    en = 1'b0;
    push_idle(2);
    run(2, "stop");
  endtask

  // Checks the idle cycle before the enabling edge, then a whole frame.
  task automatic start_frame(input logic [3:0][7:0] d, input logic [3:0] lz, input string tag);
    apply_stimulus(d);
    push_frame(d, LZ_EN ? lz : 4'hF);
    check_output(tag);
    en = 1'b1;
    run(FRAME_LEN - 1, tag);
  endtask

  initial begin
    vecs[0] = '{mk(SEG_CODES[0], SEG_CODES[1], SEG_CODES[2], SEG_CODES[3]), 4'b1111};
    vecs[1] = '{mk(8'h3F, 8'h06, 8'h3F, 8'h3F), 4'b0011};
    vecs[2] = '{mk(8'h3F, 8'h3F, 8'h3F, 8'h3F), 4'b0001};
    vecs[3] = '{mk(8'h6D, 8'h3F, 8'h3F, 8'h06), 4'b1111};
    vecs[4] = '{mk(8'h3F, 8'h3F, 8'h66, 8'h3F), 4'b0111};
    vecs[5] = '{mk(8'h7F, 8'h07, 8'h3F, 8'h3F), 4'b0011};

    button_n = 1'b1;
    en       = 1'b0;
    apply_stimulus(vecs[0].d);
    #1 button_n = 1'b0;
    @(posedge timer);
    #1;
    push_idle(1);
    check_output("reset");
    button_n = 1'b1;

    // Rotation over two frames straight out of reset.
    apply_stimulus(vecs[0].d);
    push_frame(vecs[0].d, 4'hF);
    push_frame(vecs[0].d, 4'hF);
    check_output("rotation");
    en = 1'b1;
    run(2 * FRAME_LEN - 1, "rotation");
    stop_scan();

    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].d, vecs[i].lz_mask, $sformatf("vec%0d", i));
      stop_scan();
    end

    // D1 changes during digit 0 drive: old value this frame, new value next frame.
    begin
      logic [3:0][7:0] nd;
      nd = vecs[0].d;
      nd[1] = 8'h66;
      apply_stimulus(vecs[0].d);
      push_frame(vecs[0].d, 4'hF);
      push_frame(nd, 4'hF);
      check_output("tear");
      en = 1'b1;
      run(3, "tear");
      d1 = 8'h66;
      run(2 * FRAME_LEN - 4, "tear");
      stop_scan();
    end

    // EN drops during digit 2 drive, then restarts at digit 0.
    apply_stimulus(vecs[0].d);
    push_frame(vecs[0].d, 4'hF);
    check_output("en_drop");
    en = 1'b1;
    run(15, "en_drop");
    exp_q.delete();
    en = 1'b0;
    push_idle(2);
    run(2, "en_drop_dark");
    start_frame(vecs[3].d, vecs[3].lz_mask, "en_restart");
    stop_scan();

    // EN falls exactly where FRAME would be emitted.
    apply_stimulus(vecs[0].d);
    push_frame(vecs[0].d, 4'hF);
    check_output("en_frame");
    en = 1'b1;
    run(FRAME_LEN - 2, "en_frame");
    exp_q.delete();
    en = 1'b0;
    push_idle(1);
    run(1, "en_frame_suppressed");

    // Asynchronous reset in the middle of digit 1 drive.
    apply_stimulus(vecs[0].d);
    push_frame(vecs[0].d, 4'hF);
    check_output("async_rst");
    en = 1'b1;
    run(9, "async_rst");
    exp_q.delete();
    #3 button_n = 1'b0;
    #1;
    push_idle(1);
    check_output("async_rst_immediate");
    push_idle(1);
    tick("async_rst_held");
    apply_stimulus(vecs[5].d);
    push_frame(vecs[5].d, LZ_EN ? vecs[5].lz_mask : 4'hF);
    check_output("post_reset");
    button_n = 1'b1;
    run(FRAME_LEN - 1, "post_reset");
    stop_scan();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
